// File: rtl/mod_timer_irq.sv
// rtl/mod_timer_irq.sv - memory-mapped programmable timer driving the interrupt controller's i_timer input
//
// Counts prescaled clock ticks. When COUNT matches COMPARE on a tick, it emits a one-cycle
// interrupt pulse and then either reloads COUNT to 0 (periodic) or stops (one-shot).
// All state is updated on the falling edge of clk.
//
// Register map (daddr[3:0]):
//   0x0 COUNT     0x4 COMPARE
//   0x8 CTRL      {28'b0, MATCH, OVF, PER, EN}
//   0xC PRESCALE  (present only when the prescaler is built in)
// OVF and MATCH are sticky: writing 0 clears them, writing 1 leaves them unchanged.
//
// Build option: MOD_TIMER_PRESCALER_EN
//   defined   - PRESCALE register exists; one tick every PRESCALE+1 enabled cycles
//   undefined - no prescaler; one tick every enabled cycle; 0xC reads 0 and ignores writes
//
// Ports:
//   clk      system clock (state updates on negedge)
//   rst      synchronous active-low reset
//   ie       instruction-bus enable (unused)
//   de       data-bus enable
//   iaddr    instruction address (unused)
//   daddr    data address; only bits [3:0] are decoded
//   drw      bit0 write strobe, bit1 read strobe
//   din      write data
//   iout     instruction read data, always 0
//   dout     combinational data read mux; unmapped offsets read 0
//   i_timer  registered one-cycle interrupt pulse

module mod_timer_irq #(
  parameter int          PRESCALE_W = 16,
  parameter logic [31:0] CMP_RESET  = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ie,
  input  logic        de,
  input  logic [31:0] iaddr,
  input  logic [31:0] daddr,
  input  logic [1:0]  drw,
  input  logic [31:0] din,
  output logic [31:0] iout,
  output logic [31:0] dout,
  output logic        i_timer
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        en_q, en_d;
  logic        per_q, per_d;
  logic        ovf_q, ovf_d;
  logic        match_q, match_d;
  logic        irq_q, irq_d;

  logic [3:0]  off;
  logic        wr;
  logic        wr_count, wr_compare, wr_ctrl;
  logic        tick;
  logic        is_match;
  logic [31:0] prescale_rd;

  assign off        = daddr[3:0];
  assign wr         = de & drw[0];
  assign wr_count   = wr && (off == 4'h0);
  assign wr_compare = wr && (off == 4'h4);
  assign wr_ctrl    = wr && (off == 4'h8);

`ifdef MOD_TIMER_PRESCALER_EN
  logic                  wr_prescale;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;

  assign wr_prescale = wr && (off == 4'hC);

  always_comb begin
    prescale_d = prescale_q;
    pre_cnt_d  = pre_cnt_q;
    tick       = 1'b0;
    if (wr_prescale) prescale_d = din[PRESCALE_W-1:0];
    if (en_q) begin
      if (pre_cnt_q == prescale_q) begin
        tick      = 1'b1;
        pre_cnt_d = '0;
      end else begin
        pre_cnt_d = pre_cnt_q + PRESCALE_W'(1);
      end
    end else begin
      pre_cnt_d = '0;
    end
    // A new divisor or a disable restarts the divider from zero.
    if (wr_prescale || (wr_ctrl && !din[0])) pre_cnt_d = '0;
  end

  always_ff @(negedge clk) begin
    if (!rst) begin
      prescale_q <= '0;
      pre_cnt_q  <= '0;
    end else begin
      prescale_q <= prescale_d;
      pre_cnt_q  <= pre_cnt_d;
    end
  end

  assign prescale_rd = {{(32-PRESCALE_W){1'b0}}, prescale_q};
`else
  localparam int unused_prescale_w = PRESCALE_W;
  assign tick        = en_q;
  assign prescale_rd = 32'h0;
`endif

  assign is_match = tick && (count_q == compare_q);

  always_comb begin
    count_d   = count_q;
    compare_d = compare_q;
    en_d      = en_q;
    per_d     = per_q;
    ovf_d     = ovf_q;
    match_d   = match_q;
    irq_d     = 1'b0;

    if (wr_compare) compare_d = din;

    // A bus write to COUNT wins over any tick in the same cycle: no increment, no pulse.
    if (wr_count) begin
      count_d = din;
    end else if (tick) begin
      if (is_match) begin
        irq_d   = 1'b1;
        match_d = 1'b1;
        if (per_q) count_d = 32'h0;
        else       en_d    = 1'b0;
      end else begin
        count_d = count_q + 32'd1;
        if (count_q == 32'hFFFFFFFF) ovf_d = 1'b1;
      end
    end

    // CTRL writes take precedence over the hardware updates above.
    if (wr_ctrl) begin
      en_d    = din[0];
      per_d   = din[1];
      ovf_d   = ovf_q & din[2];
      match_d = match_q & din[3];
    end
  end

  always_ff @(negedge clk) begin
    if (!rst) begin
      count_q   <= 32'h0;
      compare_q <= CMP_RESET;
      en_q      <= 1'b0;
      per_q     <= 1'b0;
      ovf_q     <= 1'b0;
      match_q   <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      en_q      <= en_d;
      per_q     <= per_d;
      ovf_q     <= ovf_d;
      match_q   <= match_d;
      irq_q     <= irq_d;
    end
  end

  always_comb begin
    dout = 32'h0;
    case (off)
      4'h0:    dout = count_q;
      4'h4:    dout = compare_q;
      4'h8:    dout = {28'h0, match_q, ovf_q, per_q, en_q};
      4'hC:    dout = prescale_rd;
      default: dout = 32'h0;
    endcase
  end

  assign iout    = 32'h0;
  assign i_timer = irq_q;

  logic unused_ok;
  assign unused_ok = &{1'b0, ie, iaddr, daddr[31:4], drw[1]};

endmodule

// File: tb/tb_mod_timer_irq.sv
// tb/tb_mod_timer_irq.sv - self-checking bench for mod_timer_irq

module tb_mod_timer_irq;

  logic        clk;
  logic        rst;
  logic        ie;
  logic        de;
  logic [31:0] iaddr;
  logic [31:0] daddr;
  logic [1:0]  drw;
  logic [31:0] din;
  logic [31:0] iout;
  logic [31:0] dout;
  logic        i_timer;

  int n_checks;
  int n_pass;

  mod_timer_irq dut (
    .clk     (clk),
    .rst     (rst),
    .ie      (ie),
    .de      (de),
    .iaddr   (iaddr),
    .daddr   (daddr),
    .drw     (drw),
    .din     (din),
    .iout    (iout),
    .dout    (dout),
    .i_timer (i_timer)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_dout;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] ed, input logic ei);
    vec_t v;
    v.rst_n = r; v.wr = w; v.addr = a; v.wdata = d; v.exp_dout = ed; v.exp_irq = ei;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Drive one bus cycle, let the falling edge update state, then sample 2ns later.
  task automatic step(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    rst   = r;
    de    = 1'b1;
    drw   = w ? 2'b01 : 2'b10;
    daddr = a;
    din   = d;
    @(negedge clk);
    #2;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b0; ie = 1'b0; de = 1'b0; iaddr = 32'h0; daddr = 32'h0; drw = 2'b00; din = 32'h0;
    #2;

    // Reset values of every register while rst is held low.
    step(1'b0, 1'b0, 32'h0, 32'h0);
    check("rst count", dout, 32'h0);
    check("rst irq", {31'h0, i_timer}, 32'h0);
    check("rst iout", iout, 32'h0);
    step(1'b0, 1'b0, 32'h4, 32'h0);
    check("rst compare", dout, 32'hFFFFFFFF);
    step(1'b0, 1'b0, 32'h8, 32'h0);
    check("rst ctrl", dout, 32'h0);
    step(1'b0, 1'b0, 32'hC, 32'h0);
    check("rst prescale", dout, 32'h0);

    // Periodic, COMPARE=3: COUNT 0,1,2,3 then pulse with reload.
    add(1, 1, 32'h4, 32'h3, 32'h3, 0);
    add(1, 1, 32'h8, 32'h3, 32'h3, 0);
    add(1, 0, 32'h0, 0, 32'h1, 0);
    add(1, 0, 32'h0, 0, 32'h2, 0);
    add(1, 0, 32'h0, 0, 32'h3, 0);
    add(1, 0, 32'h0, 0, 32'h0, 1);
    add(1, 0, 32'h0, 0, 32'h1, 0);
    add(1, 0, 32'h0, 0, 32'h2, 0);
    add(1, 0, 32'h0, 0, 32'h3, 0);
    add(1, 0, 32'h0, 0, 32'h0, 1);
    add(1, 0, 32'h0, 0, 32'h1, 0);
    add(1, 1, 32'h8, 32'h0, 32'h0, 0);
    add(1, 1, 32'h0, 32'h0, 32'h0, 0);
    add(1, 0, 32'h0, 0, 32'h0, 0);
    add(1, 0, 32'h0, 0, 32'h0, 0);
    add(1, 0, 32'h2, 0, 32'h0, 0);
    // One-shot, COMPARE=2: single pulse, EN drops, MATCH set, COUNT holds.
    add(1, 1, 32'h4, 32'h2, 32'h2, 0);
    add(1, 1, 32'h8, 32'h1, 32'h1, 0);
    add(1, 0, 32'h0, 0, 32'h1, 0);
    add(1, 0, 32'h0, 0, 32'h2, 0);
    add(1, 0, 32'h0, 0, 32'h2, 1);
    add(1, 0, 32'h8, 0, 32'h8, 0);
    add(1, 0, 32'h0, 0, 32'h2, 0);
    // Wrap FFFFFFFF->0 sets OVF without a pulse; writing OVF=0 clears it.
    add(1, 1, 32'h8, 32'h0, 32'h0, 0);
    add(1, 1, 32'h0, 32'hFFFFFFFE, 32'hFFFFFFFE, 0);
    add(1, 1, 32'h4, 32'h5, 32'h5, 0);
    add(1, 1, 32'h8, 32'h1, 32'h1, 0);
    add(1, 0, 32'h0, 0, 32'hFFFFFFFF, 0);
    add(1, 0, 32'h0, 0, 32'h0, 0);
    add(1, 0, 32'h8, 0, 32'h5, 0);
    add(1, 1, 32'h8, 32'h1, 32'h1, 0);
    add(1, 1, 32'h8, 32'h0, 32'h0, 0);
    // COUNT write in the matching tick suppresses the pulse and leaves MATCH clear.
    add(1, 1, 32'h0, 32'h0, 32'h0, 0);
    add(1, 1, 32'h4, 32'h2, 32'h2, 0);
    add(1, 1, 32'h8, 32'h3, 32'h3, 0);
    add(1, 0, 32'h0, 0, 32'h1, 0);
    add(1, 0, 32'h0, 0, 32'h2, 0);
    add(1, 1, 32'h0, 32'h0, 32'h0, 0);
    add(1, 0, 32'h8, 0, 32'h3, 0);
    add(1, 0, 32'h0, 0, 32'h2, 0);
    add(1, 0, 32'h0, 0, 32'h0, 1);
    // Reset on the cycle a pulse is due: pulse dropped, registers back to reset values.
    add(1, 0, 32'h0, 0, 32'h1, 0);
    add(1, 0, 32'h0, 0, 32'h2, 0);
    add(0, 0, 32'h0, 0, 32'h0, 0);
    add(1, 0, 32'h0, 0, 32'h0, 0);
    add(1, 0, 32'h4, 0, 32'hFFFFFFFF, 0);
    add(1, 0, 32'h8, 0, 32'h0, 0);
    add(1, 0, 32'hC, 0, 32'h0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst_n, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      check($sformatf("vec%0d dout", i), dout, vecs[i].exp_dout);
      check($sformatf("vec%0d irq", i), {31'h0, i_timer}, {31'h0, vecs[i].exp_irq});
    end

`ifdef MOD_TIMER_PRESCALER_EN
    // PRESCALE=4, COMPARE=1, periodic: COUNT steps every 5 cycles, pulse every 10.
    step(1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b1, 32'hC, 32'h4);
    check("prescale rw", dout, 32'h4);
    step(1'b1, 1'b1, 32'h4, 32'h1);
    step(1'b1, 1'b1, 32'h8, 32'h3);
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 1'b0, 32'h0, 32'h0);
      check($sformatf("pre%0d count", i), dout, ((i / 5) % 2 == 1) ? 32'h1 : 32'h0);
      check($sformatf("pre%0d irq", i), {31'h0, i_timer}, (i == 10 || i == 20) ? 32'h1 : 32'h0);
    end
`else
    // Without the prescaler, 0xC ignores writes and reads 0.
    step(1'b1, 1'b1, 32'hC, 32'h4);
    check("prescale absent", dout, 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
